mac_acc: RTL and testbench

- Next-generation MAC for the CNN conv datapath.
- Per accepted beat, it multiplies INPUT_NUM signed data/weight pairs and reduces them through a registered adder tree.
- It accumulates ACC_NUM beats into one output pixel, adding bias on the group's first beat.
- It then requantizes: rounded arithmetic right shift, optional ReLU, saturation to WDP_OUT. It sits between the line-buffer/weight fetch and the output writer.

---
 rtl/mac_pkg.sv | 49 ++++
 rtl/mac_tree.sv | 94 +++++++++
 rtl/mac_acc.sv | 157 +++++++++++++++
 tb/tb_mac_acc.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared defaults and helpers for the CNN conv MAC datapath.
package mac_pkg;

    // Default widths and geometry shared with the conv top.
    localparam int MAC_INPUT_NUM  = 4;
    localparam int MAC_WDP        = 9;
    localparam int MAC_WDP_WEIGHT = 9;
    localparam int MAC_WDP_BIAS   = 13;
    localparam int MAC_WDP_ACC    = 24;
    localparam int MAC_WDP_OUT    = 9;
    localparam int MAC_ACC_NUM    = 3;
    localparam int MAC_BIAS_SHIFT = 2;
    localparam int MAC_OUT_SHIFT  = 4;
    localparam int MAC_RELU_EN    = 1;

    // Lane count rounded up to the next power of two (adder-tree leaves).
    function automatic int pad_num(input int n);
        return 1 << $clog2(n);
    endfunction

    // Round-half-up arithmetic right shift, optional ReLU, then saturation
    // to a signed wout-bit range. Evaluated at 64 bits so no step overflows.
    function automatic logic signed [63:0] sat_round(
        input logic signed [63:0] acc,
        input int                 shift,
        input bit                 relu,
        input int                 wout
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = acc;
        if (shift > 0) begin
            r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        if (relu && (r < 0)) begin
            r = '0;
        end
        hi = (64'sd1 <<< (wout - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (wout - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_tree.sv
// Registered lane multiply followed by a pipelined adder tree, with a
// sideband bus (valid plus opaque payload) delayed to match the tree latency.
module mac_tree
    import mac_pkg::*;
#(
    parameter int INPUT_NUM  = MAC_INPUT_NUM,
    parameter int WDP        = MAC_WDP,
    parameter int WDP_WEIGHT = MAC_WDP_WEIGHT,
    parameter int WDP_ACC    = MAC_WDP_ACC,
    parameter int SB_W       = 1
)(
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            clr,
    input  logic                            i_vld,
    input  logic [SB_W-1:0]                 i_sb,
    input  logic [WDP*INPUT_NUM-1:0]        i_d,
    input  logic [WDP_WEIGHT*INPUT_NUM-1:0] i_w,
    output logic                            o_vld,
    output logic [SB_W-1:0]                 o_sb,
    output logic signed [WDP_ACC-1:0]       o_sum,
    output logic                            o_any_vld
);

    localparam int P = pad_num(INPUT_NUM);
    localparam int L = $clog2(P);
    localparam int T = L + 1;

    // Nodes are stored level by level: leaves at 0..P-1, root at 2P-2.
    function automatic int node_base(input int k);
        return 2 * P - 2 * (P >> k);
    endfunction

    logic signed [WDP_ACC-1:0] w_prod [P];
    logic signed [WDP_ACC-1:0] r_node [2*P-1];
    logic [T-1:0]              r_vld;
    logic [SB_W-1:0]           r_sb [T];

    // Lane 0 sits in the MSBs; padding lanes contribute zero.
    for (genvar g = 0; g < P; g++) begin : g_leaf
        if (g < INPUT_NUM) begin : g_lane
            logic signed [WDP-1:0]            w_dl;
            logic signed [WDP_WEIGHT-1:0]     w_wl;
            logic signed [WDP+WDP_WEIGHT-1:0] w_full;
            assign w_dl      = i_d[(INPUT_NUM-1-g)*WDP +: WDP];
            assign w_wl      = i_w[(INPUT_NUM-1-g)*WDP_WEIGHT +: WDP_WEIGHT];
            assign w_full    = w_dl * w_wl;
            assign w_prod[g] = WDP_ACC'(w_full);
        end else begin : g_pad
            assign w_prod[g] = '0;
        end
    end

    // Product register and one register per tree level.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's value from before the clock edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int n = 0; n < 2*P-1; n++) r_node[n] <= '0;
        end else begin
            for (int n = 0; n < P; n++) r_node[n] <= w_prod[n];
            for (int k = 1; k <= L; k++) begin
                for (int j = 0; j < (P >> k); j++) begin
                    r_node[node_base(k)+j] <= r_node[node_base(k-1)+2*j]
                                            + r_node[node_base(k-1)+2*j+1];
                end
            end
        end
    end

    // Sideband shift register; clr drops every beat in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
            for (int k = 0; k < T; k++) r_sb[k] <= '0;
        end else if (clr) begin
            r_vld <= '0;
            for (int k = 0; k < T; k++) r_sb[k] <= '0;
        end else begin
            r_vld[0] <= i_vld;
            r_sb[0]  <= i_sb;
            for (int k = 1; k < T; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_sb[k]  <= r_sb[k-1];
            end
        end
    end

    assign o_vld     = r_vld[T-1];
    assign o_sb      = r_sb[T-1];
    assign o_sum     = r_node[2*P-2];
    assign o_any_vld = |r_vld;

endmodule

// File: rtl/mac_acc.sv
// Conv MAC: input register, multiply/adder tree, group accumulator with
// first-beat bias, and requantization (round, ReLU, saturate) to WDP_OUT.
module mac_acc
    import mac_pkg::*;
#(
    parameter int INPUT_NUM  = MAC_INPUT_NUM,
    parameter int WDP        = MAC_WDP,
    parameter int WDP_WEIGHT = MAC_WDP_WEIGHT,
    parameter int WDP_BIAS   = MAC_WDP_BIAS,
    parameter int WDP_ACC    = MAC_WDP_ACC,
    parameter int WDP_OUT    = MAC_WDP_OUT,
    parameter int ACC_NUM    = MAC_ACC_NUM,
    parameter int BIAS_SHIFT = MAC_BIAS_SHIFT,
    parameter int OUT_SHIFT  = MAC_OUT_SHIFT,
    parameter int RELU_EN    = MAC_RELU_EN
)(
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            clr,
    input  logic                            d_en,
    input  logic [WDP*INPUT_NUM-1:0]        d,
    input  logic [WDP_WEIGHT*INPUT_NUM-1:0] w,
    input  logic [WDP_BIAS-1:0]             bias,
    output logic                            q_en,
    output logic                            q_en_b1,
    output logic [WDP_OUT-1:0]              q,
    output logic                            busy
);

    localparam int ACC_MIN = WDP + WDP_WEIGHT + $clog2(INPUT_NUM) + $clog2(ACC_NUM) + 1;
    localparam int CNT_W   = (ACC_NUM > 1) ? $clog2(ACC_NUM) : 1;

    if (WDP_ACC < ACC_MIN) begin : g_bad_acc_width
        $error("mac_acc: WDP_ACC is too narrow for the worst-case group sum");
    end

    typedef struct packed {
        logic                first;
        logic                last;
        logic [WDP_BIAS-1:0] bias;
    } sb_t;

    logic [CNT_W-1:0]                r_cnt;
    logic                            w_first;
    logic                            w_last;
    logic                            r_in_vld;
    sb_t                             r_in_sb;
    logic [WDP*INPUT_NUM-1:0]        r_in_d;
    logic [WDP_WEIGHT*INPUT_NUM-1:0] r_in_w;
    logic                            w_t_vld;
    logic [$bits(sb_t)-1:0]          w_t_sb_raw;
    sb_t                             w_t_sb;
    logic signed [WDP_ACC-1:0]       w_t_sum;
    logic                            w_t_busy;
    logic signed [WDP_ACC-1:0]       w_bias_ext;
    logic signed [WDP_ACC-1:0]       w_acc_nxt;
    logic signed [WDP_ACC-1:0]       r_acc;
    logic                            r_acc_vld;
    logic                            r_acc_last;
    logic [WDP_OUT-1:0]              r_q;
    logic                            r_q_en;

    assign w_first = (r_cnt == '0);
    assign w_last  = (r_cnt == CNT_W'(ACC_NUM - 1));

    // Beat counter and input register; clr discards a beat on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt    <= '0;
            r_in_vld <= 1'b0;
            r_in_sb  <= '0;
            r_in_d   <= '0;
            r_in_w   <= '0;
        end else begin
            r_in_d <= d;
            r_in_w <= w;
            if (clr) begin
                r_cnt    <= '0;
                r_in_vld <= 1'b0;
                r_in_sb  <= '0;
            end else begin
                r_in_vld      <= d_en;
                r_in_sb.first <= d_en & w_first;
                r_in_sb.last  <= d_en & w_last;
                r_in_sb.bias  <= bias;
                if (d_en) begin
                    r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                end
            end
        end
    end

    mac_tree #(
        .INPUT_NUM  (INPUT_NUM),
        .WDP        (WDP),
        .WDP_WEIGHT (WDP_WEIGHT),
        .WDP_ACC    (WDP_ACC),
        .SB_W       ($bits(sb_t))
    ) u_tree (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .i_vld     (r_in_vld),
        .i_sb      (r_in_sb),
        .i_d       (r_in_d),
        .i_w       (r_in_w),
        .o_vld     (w_t_vld),
        .o_sb      (w_t_sb_raw),
        .o_sum     (w_t_sum),
        .o_any_vld (w_t_busy)
    );

    assign w_t_sb     = sb_t'(w_t_sb_raw);
    assign w_bias_ext = WDP_ACC'($signed(w_t_sb.bias)) <<< BIAS_SHIFT;
    assign w_acc_nxt  = w_t_sb.first ? (w_t_sum + w_bias_ext) : (r_acc + w_t_sum);

    // Group accumulator: restart with bias on the first beat, else add.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc      <= '0;
            r_acc_vld  <= 1'b0;
            r_acc_last <= 1'b0;
        end else if (clr) begin
            r_acc      <= '0;
            r_acc_vld  <= 1'b0;
            r_acc_last <= 1'b0;
        end else begin
            r_acc_vld  <= w_t_vld;
            r_acc_last <= w_t_vld & w_t_sb.last;
            if (w_t_vld) begin
                r_acc <= w_acc_nxt;
            end
        end
    end

    assign q_en_b1 = r_acc_vld & r_acc_last;

    // Requantize a completed group; q holds between pulses and across clr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q    <= '0;
            r_q_en <= 1'b0;
        end else if (clr) begin
            r_q_en <= 1'b0;
        end else begin
            r_q_en <= q_en_b1;
            if (q_en_b1) begin
                r_q <= WDP_OUT'(sat_round(64'(r_acc), OUT_SHIFT, RELU_EN != 0, WDP_OUT));
            end
        end
    end

    assign q    = r_q;
    assign q_en = r_q_en;
    assign busy = (r_cnt != '0) | r_in_vld | w_t_busy | r_acc_vld | r_q_en;

endmodule

// File: tb/tb_mac_acc.sv
// Scoreboard bench for mac_acc: two instances (ReLU on / off) share one
// stimulus stream; a negedge monitor pops expected results on each q_en.
module tb_mac_acc;

    localparam int N  = 4;
    localparam int WD = 9;
    localparam int WB = 13;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          clr  = 1'b0;
    logic          d_en = 1'b0;
    logic [N*WD-1:0] d  = '0;
    logic [N*WD-1:0] w  = '0;
    logic [WB-1:0]   bias = '0;

    logic          q_en_a, q_en_b1_a, busy_a;
    logic [8:0]    q_a;
    logic          q_en_b, q_en_b1_b, busy_b;
    logic [8:0]    q_b;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int q_relu;
        int q_norelu;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic prev_b1_a = 1'b0;
    logic prev_b1_b = 1'b0;

    mac_acc u_dut_relu (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (clr),
        .d_en    (d_en),
        .d       (d),
        .w       (w),
        .bias    (bias),
        .q_en    (q_en_a),
        .q_en_b1 (q_en_b1_a),
        .q       (q_a),
        .busy    (busy_a)
    );

    mac_acc #(.RELU_EN(0)) u_dut_norelu (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (clr),
        .d_en    (d_en),
        .d       (d),
        .w       (w),
        .bias    (bias),
        .q_en    (q_en_b),
        .q_en_b1 (q_en_b1_b),
        .q       (q_b),
        .busy    (busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every q_en pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (prev_b1_a && !q_en_a) check("q_en after q_en_b1 (relu)", 0, 1);
        if (prev_b1_b && !q_en_b) check("q_en after q_en_b1 (norelu)", 0, 1);
        if (q_en_a || q_en_b) begin
            if (sb_q.size() == 0) begin
                check("unexpected q_en pulse", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("q_en (relu)", int'(q_en_a), 1);
                check("q_en (norelu)", int'(q_en_b), 1);
                check("q (relu)", int'($signed(q_a)), mon_e.q_relu);
                check("q (norelu)", int'($signed(q_b)), mon_e.q_norelu);
                check("q_en latency", cyc, mon_e.cyc);
                check("q_en_b1 one cycle early (relu)", int'(prev_b1_a), 1);
                check("q_en_b1 one cycle early (norelu)", int'(prev_b1_b), 1);
            end
        end
        prev_b1_a = q_en_b1_a;
        prev_b1_b = q_en_b1_b;
    end

    // Advance to the drive slot of the next cycle.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One beat with every lane carrying the same data/weight pair.
    task automatic beat(input int dv, input int wv, input int bv);
        logic [WD-1:0] dd;
        logic [WD-1:0] ww;
        dd   = dv[WD-1:0];
        ww   = wv[WD-1:0];
        d    = {N{dd}};
        w    = {N{ww}};
        bias = bv[WB-1:0];
        d_en = 1'b1;
        idle(1);
        d_en = 1'b0;
    endtask

    // Three-beat group; non-first beats carry a decoy bias that must be ignored.
    // The result appears after the 5th edge following the last beat's edge.
    task automatic group(input int dv, input int wv, input int bv, input int gap,
                         input int er, input int en);
        for (int b = 0; b < 3; b++) begin
            if (b == 2) sb_q.push_back('{er, en, cyc + 6});
            beat(dv, wv, (b == 0) ? bv : 100);
            if (gap > 0) idle(gap);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("reset q (relu)", int'(q_a), 0);
        check("reset q (norelu)", int'(q_b), 0);
        check("reset q_en", int'(q_en_a | q_en_b), 0);
        check("reset q_en_b1", int'(q_en_b1_a | q_en_b1_b), 0);
        check("reset busy", int'(busy_a | busy_b), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(1);

        // Basic: tree=4/beat, acc=12+32=44, (44+8)>>4 = 3
        group(1, 1, 8, 0, 3, 3);
        check("busy with beats in flight", int'(busy_a), 1);
        idle(10);
        check("busy idle after group", int'(busy_a | busy_b), 0);

        // ReLU: acc=-1200 -> -75, clamped to 0 with ReLU
        group(-10, 10, 0, 0, 0, -75);
        idle(10);

        // Saturation high and low
        group(255, 255, 0, 0, 255, 255);
        idle(10);
        group(-256, 255, 0, 0, 0, -256);
        idle(10);

        // Gaps of two idle cycles between beats
        group(1, 1, 8, 2, 3, 3);
        idle(10);

        // Streaming: six continuous beats, pulses three cycles apart
        group(1, 1, 8, 0, 3, 3);
        group(1, 1, 8, 0, 3, 3);
        idle(10);

        // clr mid-group, with a beat on the same edge
        beat(1, 1, 8);
        beat(1, 1, 100);
        clr = 1'b1;
        beat(1, 1, 100);
        clr = 1'b0;
        @(negedge clk);
        check("busy after clr (relu)", int'(busy_a), 0);
        check("busy after clr (norelu)", int'(busy_b), 0);
        check("q holds across clr", int'($signed(q_a)), 3);
        @(posedge clk);
        #1;
        group(1, 1, 8, 0, 3, 3);
        idle(10);

        // Asynchronous reset during the second beat
        beat(1, 1, 8);
        d    = {N{9'd1}};
        d_en = 1'b1;
        rstn = 1'b0;
        #1;
        check("async reset q (relu)", int'(q_a), 0);
        check("async reset q (norelu)", int'(q_b), 0);
        check("async reset q_en", int'(q_en_a | q_en_b), 0);
        check("async reset busy", int'(busy_a | busy_b), 0);
        d_en = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);
        group(1, 1, 8, 0, 3, 3);
        idle(12);

        check("all expected results seen", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
